// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator.
// Holds the FSM state encoding, LFSR geometry and counter sizing.
package bounce_gen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int LFSR_W = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 -> taps on bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int GAP_CNT_W = 9;

  // Wide enough to hold 2*bounces+1 remaining toggles.
  function automatic int toggle_cnt_width(input int bounces);
    return $clog2(2 * bounces + 2);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts toward the MSB with feedback into bit 0.
// Free-running: advances on every clock once out of reset.
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED;
    end else begin
      state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// Emulates mechanical contact bounce: each clean level change becomes a burst of
// 2*BOUNCES+1 toggles on bouncy, spaced by MIN_GAP plus optional LFSR jitter.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int                BOUNCES     = 3,
  parameter int                MIN_GAP     = 2,
  parameter int                GAP_WIDTH   = 4,
  parameter logic              JITTER_EN   = 1'b1,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
  parameter logic              RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clean,
  input  logic bypass,
  output logic bouncy,
  output logic busy,
  output logic done
);

  localparam int            TW      = toggle_cnt_width(BOUNCES);
  localparam logic [TW-1:0] TOGGLES = TW'(2 * BOUNCES + 1);
  localparam logic [TW-1:0] ONE_T   = TW'(1);

  generate
    if (LFSR_SEED == '0) begin : g_bad_seed
      $error("bounce_gen: LFSR_SEED must be nonzero");
    end
    if (MIN_GAP < 1 || MIN_GAP > 255) begin : g_bad_gap
      $error("bounce_gen: MIN_GAP must be in 1..255");
    end
    if (GAP_WIDTH < 1 || GAP_WIDTH > 8) begin : g_bad_width
      $error("bounce_gen: GAP_WIDTH must be in 1..8");
    end
  endgenerate

  state_t                 state, state_nx;
  logic [GAP_CNT_W-1:0]   gap_cnt, gap_nx, gap_load;
  logic [TW-1:0]          tog_left, tog_nx;
  logic                   bouncy_nx, busy_nx, done_nx;
  logic [LFSR_W-1:0]      lfsr;
  logic                   unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  // Only the low GAP_WIDTH bits feed the jitter; the rest is reduced away.
  assign unused_lfsr = ^lfsr;
  assign gap_load    = GAP_CNT_W'(MIN_GAP)
                     + (JITTER_EN ? GAP_CNT_W'(lfsr[GAP_WIDTH-1:0]) : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      tog_left <= '0;
      bouncy   <= RESET_VALUE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      gap_cnt  <= gap_nx;
      tog_left <= tog_nx;
      bouncy   <= bouncy_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bypass) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (clean != bouncy) state_nx = BURST;
        BURST:   if (gap_cnt == '0 && tog_left == ONE_T) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath next values; done is a pulse so it defaults low every cycle.
  always_comb begin
    gap_nx    = gap_cnt;
    tog_nx    = tog_left;
    bouncy_nx = bouncy;
    busy_nx   = busy;
    done_nx   = 1'b0;
    if (bypass) begin
      gap_nx    = '0;
      tog_nx    = '0;
      busy_nx   = 1'b0;
      bouncy_nx = clean;
    end else begin
      case (state)
        IDLE: begin
          busy_nx = 1'b0;
          if (clean != bouncy) begin
            gap_nx  = gap_load;
            tog_nx  = TOGGLES;
            busy_nx = 1'b1;
          end
        end
        BURST: begin
          if (gap_cnt != '0) begin
            gap_nx = gap_cnt - GAP_CNT_W'(1);
          end else begin
            bouncy_nx = ~bouncy;
            tog_nx    = tog_left - ONE_T;
            if (tog_left == ONE_T) begin
              busy_nx = 1'b0;
              done_nx = 1'b1;
            end else begin
              gap_nx = gap_load;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
